// File: rtl/ddr_cmd_sched.sv
// Serialising DDR command scheduler: one display reader and two video
// writers, with per-writer double-buffered frame banks.
module ddr_cmd_sched #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter logic [31:0]                LINE_LEN        = 32'd1280,
    parameter logic [CTRL_ADDR_WIDTH-1:0] LINE_STRIDE     = 28'd5120,
    parameter logic [15:0]                FRAME_LINES     = 16'd720,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BANK_OFFSET     = 28'h0400000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] WR0_BASE        = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] WR1_BASE        = 28'h0800000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [1:0]                 wr_req,
    input  logic [1:0]                 wr_vsync,
    output logic [1:0]                 wr_grant,
    input  logic                       rd_req,
    input  logic                       rd_vsync,
    input  logic                       rd_sel,
    output logic                       rd_grant,
    output logic                       wr_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [31:0]                wr_cmd_len,
    input  logic                       wr_cmd_ready,
    input  logic                       wr_cmd_done,
    output logic                       rd_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [31:0]                rd_cmd_len,
    input  logic                       rd_cmd_ready,
    input  logic                       rd_cmd_done,
    output logic                       busy
);

    localparam int AW = CTRL_ADDR_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           wgnt_q, wgnt_d;
    logic                 rgnt_q, rgnt_d;
    logic                 last_q, last_d;
    logic [1:0]           wbank_q, wbank_d;
    logic [1:0]           wlast_q, wlast_d;
    logic [1:0]           wpend_q, wpend_d;
    logic [1:0][15:0]     wcnt_q, wcnt_d;
    logic [1:0][AW-1:0]   waddr_q, waddr_d;
    logic                 rpend_q, rpend_d;
    logic                 rpsel_q, rpsel_d;
    logic                 rsrc_q, rsrc_d;
    logic                 rbank_q, rbank_d;
    logic [15:0]          rcnt_q, rcnt_d;
    logic [AW-1:0]        raddr_q, raddr_d;

    logic [1:0]           wvs;
    logic [1:0]           wok;
    logic                 rvs;
    logic                 rsel;
    logic                 rok;
    logic                 pick;
    logic                 wsel;

    function automatic logic [AW-1:0] base_addr(input logic ch,
                                                 input logic bank);
        logic [AW-1:0] b;
        b = ch ? WR1_BASE : WR0_BASE;
        if (bank) begin
            b = b + BANK_OFFSET;
        end
        return b;
    endfunction

    assign wsel = wgnt_q[1];

    always_comb begin
        state_d = state_q;
        wgnt_d  = wgnt_q;
        rgnt_d  = rgnt_q;
        last_d  = last_q;
        wbank_d = wbank_q;
        wlast_d = wlast_q;
        wpend_d = wpend_q;
        wcnt_d  = wcnt_q;
        waddr_d = waddr_q;
        rpend_d = rpend_q;
        rpsel_d = rpsel_q;
        rsrc_d  = rsrc_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        raddr_d = raddr_q;
        wvs     = '0;
        wok     = '0;
        rok     = 1'b0;
        pick    = 1'b0;

        // A vsync for the channel owning the path waits until it lets go.
        rvs  = rd_vsync | rpend_q;
        rsel = rd_vsync ? rd_sel : rpsel_q;
        if (rgnt_q) begin
            rpend_d = rvs;
            rpsel_d = rsel;
        end else begin
            rpend_d = 1'b0;
            if (rvs) begin
                rsrc_d  = rsel;
                rbank_d = wlast_q[rsel];
                rcnt_d  = '0;
                raddr_d = base_addr(rsel, wlast_q[rsel]);
            end
        end

        for (int i = 0; i < 2; i++) begin
            wvs[i] = wr_vsync[i] | wpend_q[i];
            if (wgnt_q[i]) begin
                wpend_d[i] = wvs[i];
            end else begin
                wpend_d[i] = 1'b0;
                if (wvs[i]) begin
                    if (wcnt_q[i] == FRAME_LINES) begin
                        wbank_d[i] = ~wbank_q[i];
                        wlast_d[i] = wbank_q[i];
                    end
                    wcnt_d[i]  = '0;
                    waddr_d[i] = base_addr(i[0], wbank_d[i]);
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                rok = rd_req & (rcnt_d < FRAME_LINES);
                for (int i = 0; i < 2; i++) begin
                    wok[i] = wr_req[i] & (wcnt_d[i] < FRAME_LINES);
                end
                pick = wok[~last_q] ? ~last_q : last_q;
                if (rok) begin
                    rgnt_d  = 1'b1;
                    state_d = S_ISSUE;
                end else if (|wok) begin
                    wgnt_d  = pick ? 2'b10 : 2'b01;
                    last_d  = pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rgnt_q ? rd_cmd_ready : wr_cmd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rgnt_q && rd_cmd_done) begin
                    rcnt_d  = rcnt_q + 16'd1;
                    raddr_d = raddr_q + LINE_STRIDE;
                    rgnt_d  = 1'b0;
                    state_d = S_IDLE;
                end else if ((|wgnt_q) && wr_cmd_done) begin
                    wcnt_d[wsel]  = wcnt_q[wsel] + 16'd1;
                    waddr_d[wsel] = waddr_q[wsel] + LINE_STRIDE;
                    wgnt_d        = '0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wgnt_d  = '0;
                rgnt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            wgnt_q  <= '0;
            rgnt_q  <= 1'b0;
            last_q  <= 1'b1;
            wbank_q <= '0;
            wlast_q <= '0;
            wpend_q <= '0;
            wcnt_q  <= '0;
            waddr_q <= {WR1_BASE, WR0_BASE};
            rpend_q <= 1'b0;
            rpsel_q <= 1'b0;
            rsrc_q  <= 1'b0;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
            raddr_q <= WR0_BASE;
        end else begin
            state_q <= state_d;
            wgnt_q  <= wgnt_d;
            rgnt_q  <= rgnt_d;
            last_q  <= last_d;
            wbank_q <= wbank_d;
            wlast_q <= wlast_d;
            wpend_q <= wpend_d;
            wcnt_q  <= wcnt_d;
            waddr_q <= waddr_d;
            rpend_q <= rpend_d;
            rpsel_q <= rpsel_d;
            rsrc_q  <= rsrc_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
            raddr_q <= raddr_d;
        end
    end

    assign wr_grant    = wgnt_q;
    assign rd_grant    = rgnt_q;
    assign busy        = (state_q != S_IDLE);
    assign wr_cmd_en   = (state_q == S_ISSUE) & (|wgnt_q) & wr_cmd_ready;
    assign rd_cmd_en   = (state_q == S_ISSUE) & rgnt_q & rd_cmd_ready;
    assign wr_cmd_addr = (|wgnt_q) ? waddr_q[wsel] : '0;
    assign rd_cmd_addr = rgnt_q ? raddr_q : '0;
    assign wr_cmd_len  = LINE_LEN;
    assign rd_cmd_len  = LINE_LEN;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Bench for ddr_cmd_sched: directed frame/arbitration scenarios plus
// random traffic, all checked against a transaction-level model.
module tb_ddr_cmd_sched;

    localparam logic [15:0] FL  = 16'd4;
    localparam logic [27:0] STR = 28'd5120;
    localparam logic [27:0] OFF = 28'h0400000;
    localparam logic [27:0] B0  = 28'h0000000;
    localparam logic [27:0] B1  = 28'h0800000;
    localparam logic [31:0] LEN = 32'd1280;

    logic        clk;
    logic        rstn;
    logic [1:0]  wr_req, wr_vsync, wr_grant;
    logic        rd_req, rd_vsync, rd_sel, rd_grant;
    logic        wr_cmd_en, rd_cmd_en;
    logic [27:0] wr_cmd_addr, rd_cmd_addr;
    logic [31:0] wr_cmd_len, rd_cmd_len;
    logic        wr_cmd_ready, rd_cmd_ready;
    logic        wr_cmd_done, rd_cmd_done;
    logic        busy;

    ddr_cmd_sched #(.FRAME_LINES(FL)) dut (
        .clk(clk), .rstn(rstn),
        .wr_req(wr_req), .wr_vsync(wr_vsync), .wr_grant(wr_grant),
        .rd_req(rd_req), .rd_vsync(rd_vsync), .rd_sel(rd_sel),
        .rd_grant(rd_grant),
        .wr_cmd_en(wr_cmd_en), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_done(wr_cmd_done),
        .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_done(rd_cmd_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int gcnt    = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Model: channel index 0/1 = writers, 2 = reader.
    int          own;
    bit          iss;
    logic [15:0] mcnt[3];
    logic [27:0] maddr[3];
    bit          mbank[2];
    bit          mlast[2];
    bit          mpend[3];
    bit          mpsel;
    int          mlastw;

    function automatic logic [27:0] mbase(input int c, input bit bk);
        return (c == 1 ? B1 : B0) + (bk ? OFF : 28'd0);
    endfunction

    task automatic m_reset();
        own = -1; iss = 0;
        for (int c = 0; c < 3; c++) begin
            mcnt[c] = 0; mpend[c] = 0;
        end
        maddr[0] = B0; maddr[1] = B1; maddr[2] = B0;
        mbank[0] = 0; mbank[1] = 0; mlast[0] = 0; mlast[1] = 0;
        mpsel = 0; mlastw = 1;
    endtask

    task automatic m_step();
        bit v, s, rdy, dn;
        int first;
        if (!rstn) begin
            m_reset();
            return;
        end
        v = rd_vsync || mpend[2];
        s = rd_vsync ? rd_sel : mpsel;
        if (own == 2) begin
            mpend[2] = v; mpsel = s;
        end else if (v) begin
            mpend[2] = 0; mcnt[2] = 0;
            maddr[2] = mbase(int'(s), mlast[s]);
        end
        for (int c = 0; c < 2; c++) begin
            v = wr_vsync[c] || mpend[c];
            if (own == c) mpend[c] = v;
            else if (v) begin
                mpend[c] = 0;
                if (mcnt[c] == FL) begin
                    mlast[c] = mbank[c];
                    mbank[c] = !mbank[c];
                end
                mcnt[c] = 0;
                maddr[c] = mbase(c, mbank[c]);
            end
        end
        if (own < 0) begin
            iss = 0;
            first = (mlastw == 0) ? 1 : 0;
            if (rd_req && mcnt[2] < FL) own = 2;
            else if (wr_req[first] && mcnt[first] < FL) own = first;
            else if (wr_req[1-first] && mcnt[1-first] < FL) own = 1 - first;
            if (own == 0 || own == 1) mlastw = own;
        end else begin
            rdy = (own == 2) ? rd_cmd_ready : wr_cmd_ready;
            dn  = (own == 2) ? rd_cmd_done : wr_cmd_done;
            if (!iss) begin
                if (rdy) iss = 1;
            end else if (dn) begin
                mcnt[own]  = mcnt[own] + 16'd1;
                maddr[own] = maddr[own] + STR;
                own = -1;
            end
        end
    endtask

    initial m_reset();

    logic [127:0] act_v, exp_v;
    logic [27:0]  e_wa, e_ra;
    always @(negedge clk) begin
        e_wa = 28'd0; e_ra = 28'd0;
        if (own == 0 || own == 1) e_wa = maddr[own];
        if (own == 2) e_ra = maddr[2];
        act_v = {2'b0, wr_grant, rd_grant, wr_cmd_en, rd_cmd_en, busy,
                 wr_cmd_addr, rd_cmd_addr, wr_cmd_len, rd_cmd_len};
        exp_v = {2'b0, own == 1, own == 0, own == 2,
                 (own == 0 || own == 1) && !iss && wr_cmd_ready,
                 own == 2 && !iss && rd_cmd_ready, own >= 0,
                 e_wa, e_ra, LEN, LEN};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model t=%0t got %h want %h", $time, act_v, exp_v);
        end
        if (wr_grant[0] === 1'b1) gcnt++;
        m_step();
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 0; wr_req = 0; wr_vsync = 0; rd_req = 0; rd_vsync = 0;
        rd_sel = 0; wr_cmd_ready = 1; rd_cmd_ready = 1;
        wr_cmd_done = 0; rd_cmd_done = 0;
        nxt(); nxt();
        rstn = 1;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst grant", {wr_grant, rd_grant}, 0);
        chk("rst en", {wr_cmd_en, rd_cmd_en}, 0);
        chk("rst len", {wr_cmd_len, rd_cmd_len}, {LEN, LEN});
        nxt();
    endtask

    // Serve one line: wait for en, check it, then done after dly cycles.
    task automatic serve(input string nm, input bit is_rd,
                         input logic [1:0] wg, input logic [27:0] ea,
                         input int dly, input bit vs, output int waited);
        bit got;
        got = 0; waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr_cmd_en || rd_cmd_en) begin
                got = 1;
                break;
            end
            nxt();
            waited++;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no cmd_en within 40 cycles", nm);
            return;
        end
        chk({nm, " en"}, {wr_cmd_en, rd_cmd_en}, is_rd ? 2'b01 : 2'b10);
        chk({nm, " gnt"}, {wr_grant, rd_grant}, {wg, is_rd});
        chk({nm, " addr"}, is_rd ? rd_cmd_addr : wr_cmd_addr, ea);
        chk({nm, " len"}, is_rd ? rd_cmd_len : wr_cmd_len, LEN);
        nxt();
        if (is_rd) rd_req = 0;
        else wr_req = wr_req & ~wg;
        if (vs) wr_vsync = wg;
        for (int j = 0; j < dly; j++) begin
            nxt();
            wr_vsync = 0;
        end
        if (is_rd) rd_cmd_done = 1;
        else wr_cmd_done = 1;
        nxt();
        rd_cmd_done = 0; wr_cmd_done = 0; wr_vsync = 0;
    endtask

    int w;
    initial begin
        do_reset();

        gcnt = 0;
        wr_req = 2'b01;
        serve("t1", 0, 2'b01, 28'h0000000, 19, 0, w);
        @(negedge clk);
        chk("t1 gnt drop", wr_grant, 2'b00);
        chk("t1 gnt cycles", gcnt, 21);
        nxt();
        wr_req = 2'b01;
        serve("t1 next", 0, 2'b01, 28'h0001400, 2, 0, w);

        do_reset();
        wr_req = 2'b11;
        serve("rr0", 0, 2'b01, 28'h0000000, 1, 0, w);
        wr_req = wr_req | 2'b01;
        serve("rr1", 0, 2'b10, 28'h0800000, 1, 0, w);
        wr_req = wr_req | 2'b10;
        serve("rr2", 0, 2'b01, 28'h0001400, 1, 0, w);
        serve("rr3", 0, 2'b10, 28'h0801400, 1, 0, w);

        do_reset();
        rd_req = 1; wr_req = 2'b10;
        serve("rdpri", 1, 2'b00, 28'h0000000, 3, 0, w);
        serve("wr after rd", 0, 2'b10, 28'h0800000, 1, 0, w);
        chk("wr after rd gap", w, 1);

        do_reset();
        for (int l = 0; l < 4; l++) begin
            wr_req = 2'b01;
            serve("frame", 0, 2'b01, STR * 28'(l), 1, 0, w);
        end
        wr_req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("line5 blocked", {wr_grant, busy}, 0);
            nxt();
        end
        wr_vsync = 2'b01;
        nxt();
        wr_vsync = 2'b00;
        serve("bank1", 0, 2'b01, 28'h0400000, 1, 0, w);
        rd_vsync = 1; rd_sel = 0;
        nxt();
        rd_vsync = 0; rd_req = 1;
        serve("rd sel0", 1, 2'b00, 28'h0000000, 1, 0, w);
        rd_req = 1;
        serve("rd sel0 l1", 1, 2'b00, 28'h0001400, 1, 0, w);
        rd_vsync = 1; rd_sel = 1;
        nxt();
        rd_vsync = 0; rd_req = 1;
        serve("rd sel1", 1, 2'b00, 28'h0800000, 1, 0, w);

        wr_req = 2'b01;
        serve("part l1", 0, 2'b01, 28'h0401400, 1, 0, w);
        wr_vsync = 2'b01;
        nxt();
        wr_vsync = 2'b00;
        wr_req = 2'b01;
        serve("part vs", 0, 2'b01, 28'h0400000, 3, 1, w);
        wr_req = 2'b01;
        serve("after pend", 0, 2'b01, 28'h0400000, 1, 0, w);

        wr_req = 2'b01;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_cmd_en) break;
            nxt();
        end
        nxt();
        wr_req = 0;
        rstn = 0;
        nxt();
        rstn = 1; wr_cmd_done = 1;
        @(negedge clk);
        chk("rst wait busy", busy, 0);
        chk("rst wait gnt", {wr_grant, rd_grant}, 0);
        nxt();
        wr_cmd_done = 0;
        @(negedge clk);
        chk("late done", busy, 0);
        nxt();
        wr_req = 2'b01;
        serve("post rst", 0, 2'b01, 28'h0000000, 1, 0, w);

        for (int c = 0; c < 3000; c++) begin
            rstn         = ($urandom_range(0, 499) != 0);
            wr_req       = 2'($urandom_range(0, 3));
            rd_req       = ($urandom_range(0, 3) == 0);
            wr_vsync[0]  = ($urandom_range(0, 29) == 0);
            wr_vsync[1]  = ($urandom_range(0, 29) == 0);
            rd_vsync     = ($urandom_range(0, 29) == 0);
            rd_sel       = 1'($urandom_range(0, 1));
            wr_cmd_ready = ($urandom_range(0, 3) != 0);
            rd_cmd_ready = ($urandom_range(0, 3) != 0);
            wr_cmd_done  = ($urandom_range(0, 3) == 0);
            rd_cmd_done  = ($urandom_range(0, 3) == 0);
            nxt();
        end
        nxt(); nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
